// File: rtl/ava_wb_dma.sv
// ava_wb_dma: single-channel Wishbone (pipelined) DMA master.
// Copies length 32-bit words from src_addr to dst_addr, one request at a time.
// Optional fill mode (write fill_value to dst) is built only when the macro
// AVA_DMA_FILL_EN is defined; otherwise every transfer runs as a copy.
module ava_wb_dma #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [31:0]           fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i,
  input  logic                  wb_err_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [31:0]           data_q;
  logic                  mode_q;
  logic                  error_q;
  logic                  start_fill;
  logic [31:0]           start_fill_word;
  logic                  load;
  logic                  capture;
  logic                  advance;
  logic                  set_err;

`ifdef AVA_DMA_FILL_EN
  assign start_fill      = mode;
  assign start_fill_word = fill_value;
`else
  logic unused_fill;
  assign start_fill      = 1'b0;
  assign start_fill_word = 32'h0;
  assign unused_fill     = ^{mode, fill_value};
`endif

  assign error = error_q;

  // State register; reset always lands in IDLE without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and bus outputs, decoded from the registered state only.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    wb_cyc_o   = 1'b0;
    wb_stb_o   = 1'b0;
    wb_we_o    = 1'b0;
    wb_adr_o   = '0;
    wb_dat_o   = '0;
    wb_sel_o   = 4'b0000;
    load       = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    set_err    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (length == '0)    next_state = FINISH;
          else if (start_fill) next_state = WR_REQ;
          else                 next_state = RD_REQ;
        end
      end
      RD_REQ: begin
        busy     = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_sel_o = 4'b1111;
        wb_adr_o = src_q;
        if (!wb_stall_i) next_state = RD_WAIT;
      end
      RD_WAIT: begin
        busy     = 1'b1;
        wb_cyc_o = 1'b1;
        if (wb_err_i) begin
          set_err    = 1'b1;
          next_state = FINISH;
        end else if (wb_ack_i) begin
          capture    = 1'b1;
          next_state = WR_REQ;
        end
      end
      WR_REQ: begin
        busy     = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_sel_o = 4'b1111;
        wb_adr_o = dst_q;
        wb_dat_o = data_q;
        if (!wb_stall_i) next_state = WR_WAIT;
      end
      WR_WAIT: begin
        busy     = 1'b1;
        wb_cyc_o = 1'b1;
        if (wb_err_i) begin
          set_err    = 1'b1;
          next_state = FINISH;
        end else if (wb_ack_i) begin
          advance = 1'b1;
          if (rem_q == LEN_WIDTH'(1)) next_state = FINISH;
          else if (mode_q)            next_state = WR_REQ;
          else                        next_state = RD_REQ;
        end
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch the job on start, capture read data, step pointers per write ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if (load) begin
        src_q   <= src_addr & WORD_MASK;
        dst_q   <= dst_addr & WORD_MASK;
        rem_q   <= length;
        mode_q  <= start_fill;
        error_q <= 1'b0;
        if (start_fill) data_q <= start_fill_word;
      end
      if (capture) data_q <= wb_dat_i;
      if (advance) begin
        if (!mode_q) src_q <= src_q + WORD_STEP;
        dst_q <= dst_q + WORD_STEP;
        rem_q <= rem_q - LEN_WIDTH'(1);
      end
      if (set_err) error_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ava_wb_dma.sv
// tb_ava_wb_dma: directed bench for ava_wb_dma with a memory-backed Wishbone
// slave and an expected-request queue built from each job's parameters.
module tb_ava_wb_dma;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  localparam logic [31:0] WORD_A = 32'hA5A5_0001;
  localparam logic [31:0] WORD_B = 32'hB6B6_0002;
  localparam logic [31:0] WORD_C = 32'hC7C7_0003;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] length;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic        error;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i   = 32'h0;
  logic        wb_ack_i   = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic        wb_err_i   = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  req_t        exp_q [$];

  int          stall_cycles = 0;
  int          ack_delay    = 0;
  int          err_on_write = 0;
  bit          ack_pending  = 1'b0;
  int          ack_wait     = 0;
  bit          pend_we      = 1'b0;
  bit          pend_err     = 1'b0;
  logic [31:0] pend_adr     = 32'h0;
  logic [31:0] pend_dat     = 32'h0;
  bit          req_seen     = 1'b0;
  int          stall_left   = 0;
  int          ack_count    = 0;
  int          read_count   = 0;
  int          write_count  = 0;
  int          done_count   = 0;
  bit          cyc_seen     = 1'b0;
  bit          reset_pulsed = 1'b0;
  bit          prev_stalled = 1'b0;
  logic        prev_we      = 1'b0;
  logic [31:0] prev_adr     = 32'h0;
  logic [31:0] prev_dat     = 32'h0;

  ava_wb_dma dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_stall_i (wb_stall_i),
    .wb_err_i   (wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Expected bus requests for one job: reads then writes per word, addresses
  // wrapping mod 2^32, truncated after the write that the slave will error.
  task automatic buildExpected(input bit m, input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] len, input logic [31:0] fv);
    bit          fill_eff;
    logic [31:0] sa;
    logic [31:0] da;
    req_t        r;
`ifdef AVA_DMA_FILL_EN
    fill_eff = m;
`else
    fill_eff = 1'b0;
`endif
    sa = s & 32'hFFFF_FFFC;
    da = d & 32'hFFFF_FFFC;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      if (!fill_eff) begin
        r.we = 1'b0; r.adr = sa + 32'(4 * i); r.dat = 32'h0;
        exp_q.push_back(r);
      end
      r.we  = 1'b1;
      r.adr = da + 32'(4 * i);
      r.dat = fill_eff ? fv : memRead(sa + 32'(4 * i));
      exp_q.push_back(r);
      if (err_on_write == i + 1) break;
    end
  endtask

  // Slave plus per-cycle protocol checker, both on the falling edge.
  always @(negedge clk) begin
    req_t e;
    bit   outstanding;
    outstanding = ack_pending;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    if (ack_pending) begin
      if (ack_wait > 0) ack_wait--;
      else begin
        ack_pending = 1'b0;
        wb_ack_i    = 1'b1;
        ack_count++;
        if (pend_err)     wb_err_i = 1'b1;
        else if (pend_we) mem[pend_adr] = pend_dat;
        else              wb_dat_i = memRead(pend_adr);
      end
    end
    if (wb_stb_o) begin
      checkOutput("cyc_with_stb", wb_cyc_o, 1);
      checkOutput("sel_with_stb", wb_sel_o, 4'hF);
    end
    if (outstanding) begin
      checkOutput("single_outstanding", wb_stb_o, 0);
      if (!reset_pulsed) checkOutput("cyc_held", wb_cyc_o, 1);
    end
    if (prev_stalled && !reset_pulsed) begin
      checkOutput("stall_stb_hold", wb_stb_o, 1);
      checkOutput("stall_we_hold", wb_we_o, prev_we);
      checkOutput("stall_adr_hold", wb_adr_o, prev_adr);
      checkOutput("stall_dat_hold", wb_dat_o, prev_dat);
    end
    if (done) begin
      done_count++;
      checkOutput("busy_in_done", busy, 0);
      checkOutput("cyc_in_done", wb_cyc_o, 0);
    end
    if (wb_cyc_o) cyc_seen = 1'b1;
    wb_stall_i = 1'b0;
    if (wb_cyc_o && wb_stb_o) begin
      if (!req_seen) begin
        req_seen   = 1'b1;
        stall_left = stall_cycles;
      end
      if (stall_left > 0) begin
        wb_stall_i = 1'b1;
        stall_left--;
      end else begin
        req_seen = 1'b0;
        if (exp_q.size() == 0) checkOutput("extra_request", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("req_we", wb_we_o, e.we);
          checkOutput("req_adr", wb_adr_o, e.adr);
          if (e.we) checkOutput("req_dat", wb_dat_o, e.dat);
        end
        ack_pending = 1'b1;
        ack_wait    = ack_delay;
        pend_we     = wb_we_o;
        pend_adr    = wb_adr_o;
        pend_dat    = wb_dat_o;
        pend_err    = 1'b0;
        if (wb_we_o) begin
          write_count++;
          pend_err = (write_count == err_on_write);
        end else read_count++;
      end
    end else req_seen = 1'b0;
    prev_stalled = wb_stb_o && wb_stall_i;
    prev_we      = wb_we_o;
    prev_adr     = wb_adr_o;
    prev_dat     = wb_dat_o;
  end

  // Launch one job and pin the first-cycle response.
  task automatic applyStimulus(input bit m, input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] len, input logic [31:0] fv);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
    ack_count = 0; read_count = 0; write_count = 0; done_count = 0; cyc_seen = 1'b0;
    buildExpected(m, s, d, len, fv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 16'd0) begin
      checkOutput("len0_done", done, 1);
      checkOutput("len0_cyc", wb_cyc_o, 0);
    end else begin
      checkOutput("busy_after_start", busy, 1);
      checkOutput("cyc_after_start", wb_cyc_o, 1);
      checkOutput("stb_after_start", wb_stb_o, 1);
    end
    checkOutput("error_after_start", error, 0);
  endtask

  // Wait (bounded) for done; optionally poke start while busy and in the done cycle.
  task automatic waitDone(input int max_cycles, input bit poke);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < max_cycles) begin
      @(negedge clk);
      n++;
      if (done) begin
        got   = 1'b1;
        start = poke;
      end else begin
        start = poke && (n % 3 == 0);
        if (poke) begin
          src_addr = 32'h900; dst_addr = 32'h900; length = 16'd7;
        end
      end
    end
    if (!got) checkOutput("done_timeout", 0, 1);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_done", busy, 0);
    checkOutput("cyc_after_done", wb_cyc_o, 0);
    checkOutput("expected_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = 32'h0; dst_addr = 32'h0; length = 16'h0; fill_value = 32'h0;
    mem[32'h100] = WORD_A; mem[32'h104] = WORD_B; mem[32'h108] = WORD_C;
    for (int i = 0; i < 5; i++) mem[32'h300 + 32'(4 * i)] = 32'hD000_0000 + 32'(i);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_cyc", wb_cyc_o, 0);
    checkOutput("rst_stb", wb_stb_o, 0);
    checkOutput("rst_we", wb_we_o, 0);
    checkOutput("rst_adr", wb_adr_o, 0);
    checkOutput("rst_dat", wb_dat_o, 0);
    checkOutput("rst_sel", wb_sel_o, 0);
    reset = 1'b0;

    $display("[TB] copy 3 words, zero-wait slave");
    applyStimulus(1'b0, 32'h100, 32'h2000, 16'd3, 32'h0);
    waitDone(50, 1'b0);
    checkOutput("copy_w0", memRead(32'h2000), WORD_A);
    checkOutput("copy_w1", memRead(32'h2004), WORD_B);
    checkOutput("copy_w2", memRead(32'h2008), WORD_C);
    checkOutput("copy_acks", ack_count, 6);
    checkOutput("copy_done_count", done_count, 1);
    checkOutput("copy_error", error, 0);

    stall_cycles = 2;
`ifdef AVA_DMA_FILL_EN
    $display("[TB] fill 4 words with stalls");
    applyStimulus(1'b1, 32'h0, 32'h40, 16'd4, 32'h00FF_00FF);
    waitDone(100, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput("fill_word", memRead(32'h40 + 32'(4 * i)), 32'h00FF_00FF);
    checkOutput("fill_reads", read_count, 0);
    checkOutput("fill_writes", write_count, 4);
`else
    $display("[TB] mode=1 runs as copy, with stalls");
    applyStimulus(1'b1, 32'h100, 32'h40, 16'd3, 32'h00FF_00FF);
    waitDone(100, 1'b0);
    checkOutput("nofill_w0", memRead(32'h40), WORD_A);
    checkOutput("nofill_w2", memRead(32'h48), WORD_C);
    checkOutput("nofill_reads", read_count, 3);
`endif
    stall_cycles = 0;

    $display("[TB] zero-length job");
    applyStimulus(1'b0, 32'h100, 32'h6000, 16'd0, 32'h0);
    @(negedge clk);
    checkOutput("len0_done_once", done, 0);
    checkOutput("len0_busy", busy, 0);
    repeat (2) @(negedge clk);
    checkOutput("len0_no_cyc", cyc_seen, 0);
    checkOutput("len0_done_count", done_count, 1);

    $display("[TB] error on second write");
    err_on_write = 2;
    applyStimulus(1'b0, 32'h300, 32'h3000, 16'd5, 32'h0);
    waitDone(60, 1'b0);
    checkOutput("err_flag", error, 1);
    checkOutput("err_done_count", done_count, 1);
    checkOutput("err_first_word", memRead(32'h3000), 32'hD000_0000);
    checkOutput("err_second_absent", mem.exists(32'h3004), 0);
    err_on_write = 0;
    applyStimulus(1'b0, 32'h300, 32'h3100, 16'd1, 32'h0);
    waitDone(30, 1'b0);
    checkOutput("err_cleared", error, 0);

    $display("[TB] reset during read wait");
    ack_delay = 3;
    applyStimulus(1'b0, 32'h100, 32'h5000, 16'd2, 32'h0);
    for (int i = 0; i < 10 && !(wb_cyc_o && !wb_stb_o); i++) @(negedge clk);
    checkOutput("in_read_wait", wb_cyc_o && !wb_stb_o, 1);
    reset_pulsed = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    checkOutput("rst_mid_cyc", wb_cyc_o, 0);
    checkOutput("rst_mid_done", done, 0);
    repeat (6) @(negedge clk);
    checkOutput("late_ack_cyc", wb_cyc_o, 0);
    checkOutput("late_ack_busy", busy, 0);
    checkOutput("rst_no_done", done_count, 0);
    checkOutput("late_ack_seen", ack_count, 1);
    reset_pulsed = 1'b0;
    ack_delay = 0;
    applyStimulus(1'b0, 32'h104, 32'h5000, 16'd1, 32'h0);
    waitDone(30, 1'b0);
    checkOutput("post_rst_copy", memRead(32'h5000), WORD_B);

    $display("[TB] ignored starts and destination wrap");
    applyStimulus(1'b0, 32'h100, 32'hFFFF_FFFC, 16'd2, 32'h0);
    waitDone(50, 1'b1);
    checkOutput("wrap_w0", memRead(32'hFFFF_FFFC), WORD_A);
    checkOutput("wrap_w1", memRead(32'h0000_0000), WORD_B);
    checkOutput("wrap_writes", write_count, 2);
    checkOutput("wrap_done_count", done_count, 1);
    repeat (3) @(negedge clk);
    checkOutput("finish_start_ignored", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
